// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle main controller: state codes, datapath select
// encodings and the packed control vector handed from the output decoder to the top.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] AluSrcAReg = 2'b00;
  localparam logic [1:0] AluSrcAPc  = 2'b01;

  localparam logic [1:0] AluSrcBReg  = 2'b00;
  localparam logic [1:0] AluSrcBImm  = 2'b01;
  localparam logic [1:0] AluSrcBFour = 2'b10;

  localparam logic [1:0] ResultAluOut = 2'b00;
  localparam logic [1:0] ResultRdData = 2'b01;
  localparam logic [1:0] ResultAlu    = 2'b10;

  localparam logic [1:0] OpDp  = 2'b00;
  localparam logic [1:0] OpMem = 2'b01;
  localparam logic [1:0] OpBr  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mcyc_out_decode.sv
// Combinational Moore output decode: state (plus mem_ready for the handshake strobes)
// to the datapath control vector. Strobes are suppressed while en_i is low.
module mcyc_out_decode
  import ctrl_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic [1:0] op_i,
  input  logic       mem_ready_i,
  input  logic       en_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      FETCH: begin
        ctrl_o.alu_src_a  = AluSrcAPc;
        ctrl_o.alu_src_b  = AluSrcBFour;
        ctrl_o.result_src = ResultAlu;
        ctrl_o.ir_write   = mem_ready_i;
        ctrl_o.next_pc    = mem_ready_i;
      end
      DECODE: begin
        ctrl_o.alu_src_a  = AluSrcAPc;
        ctrl_o.alu_src_b  = AluSrcBFour;
        ctrl_o.result_src = ResultAlu;
        if (op_i == 2'b11) begin
          ctrl_o.illegal    = 1'b1;
          ctrl_o.instr_done = 1'b1;
        end
      end
      EXECUTER: begin
        ctrl_o.alu_src_a = AluSrcAReg;
        ctrl_o.alu_src_b = AluSrcBReg;
        ctrl_o.alu_op    = 1'b1;
      end
      EXECUTEI: begin
        ctrl_o.alu_src_a = AluSrcAReg;
        ctrl_o.alu_src_b = AluSrcBImm;
        ctrl_o.alu_op    = 1'b1;
      end
      ALUWB: begin
        ctrl_o.result_src = ResultAluOut;
        ctrl_o.reg_w      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMADR: begin
        ctrl_o.alu_src_a = AluSrcAReg;
        ctrl_o.alu_src_b = AluSrcBImm;
      end
      MEMRD: begin
        ctrl_o.adr_src = 1'b1;
      end
      MEMWB: begin
        ctrl_o.result_src = ResultRdData;
        ctrl_o.reg_w      = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.mem_w      = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      BRANCH: begin
        ctrl_o.alu_src_a  = AluSrcAReg;
        ctrl_o.alu_src_b  = AluSrcBImm;
        ctrl_o.result_src = ResultAlu;
        ctrl_o.branch     = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase

    // Selects keep their FETCH values under reset; only the strobes are forced low.
    if (!en_i) begin
      ctrl_o.ir_write   = 1'b0;
      ctrl_o.next_pc    = 1'b0;
      ctrl_o.reg_w      = 1'b0;
      ctrl_o.mem_w      = 1'b0;
      ctrl_o.branch     = 1'b0;
      ctrl_o.instr_done = 1'b0;
      ctrl_o.illegal    = 1'b0;
    end
  end

endmodule

// File: rtl/mcyc_ctrl_fsm.sv
// Multicycle main controller: state register and next-state logic sequencing
// fetch/decode/execute/memory/writeback; output decode lives in mcyc_out_decode.
module mcyc_ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // Funct[4:1] is consumed by the ALU decoder, not by this controller.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (Op)
          OpDp:    state_d = Funct[5] ? EXECUTEI : EXECUTER;
          OpMem:   state_d = MEMADR;
          OpBr:    state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      MEMADR:   state_d = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    if (mem_ready) state_d = MEMWB;
      MEMWB:    state_d = FETCH;
      MEMWR:    if (mem_ready) state_d = FETCH;
      BRANCH:   state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  mcyc_out_decode u_out_decode (
    .state_i     (state_q),
    .op_i        (Op),
    .mem_ready_i (mem_ready),
    .en_i        (reset),
    .ctrl_o      (ctrl)
  );

  assign IRWrite    = ctrl.ir_write;
  assign NextPC     = ctrl.next_pc;
  assign AdrSrc     = ctrl.adr_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ResultSrc  = ctrl.result_src;
  assign RegW       = ctrl.reg_w;
  assign MemW       = ctrl.mem_w;
  assign Branch     = ctrl.branch;
  assign ALUOp      = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;
  assign state      = state_q;

endmodule

// File: tb/tb_mcyc_ctrl_fsm.sv
// Self-checking bench for mcyc_ctrl_fsm: per-cycle expected control vectors are queued
// as stimulus is driven and compared on the falling edge.
module tb_mcyc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       mem_ready;
  logic       IRWrite, NextPC, AdrSrc, RegW, MemW, Branch, ALUOp, instr_done, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] state;

  always #5 clk = ~clk;

  mcyc_ctrl_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .Op         (Op),
    .Funct      (Funct),
    .mem_ready  (mem_ready),
    .IRWrite    (IRWrite),
    .NextPC     (NextPC),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .RegW       (RegW),
    .MemW       (MemW),
    .Branch     (Branch),
    .ALUOp      (ALUOp),
    .instr_done (instr_done),
    .illegal    (illegal),
    .state      (state)
  );

  typedef struct {
    string       name;
    logic [18:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  logic prev_done = 1'b0;

  wire [18:0] dut_vec = {state, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
                         RegW, MemW, Branch, ALUOp, instr_done, illegal};

  function automatic logic [18:0] mk(input logic [3:0] st, input logic irw, input logic npc,
                                     input logic adr, input logic [1:0] asa,
                                     input logic [1:0] asb, input logic [1:0] rs,
                                     input logic regw, input logic memw, input logic br,
                                     input logic aluop, input logic done, input logic ill);
    return {st, irw, npc, adr, asa, asb, rs, regw, memw, br, aluop, done, ill};
  endfunction

  // Expected vectors, written straight from the state table.
  function automatic logic [18:0] e_rst();
    return mk(4'd0, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [18:0] e_fetch(input logic mr);
    return mk(4'd0, mr, mr, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [18:0] e_decode(input logic ill);
    return mk(4'd1, 0, 0, 0, 2'b01, 2'b10, 2'b10, 0, 0, 0, 0, ill, ill);
  endfunction
  function automatic logic [18:0] e_execr();
    return mk(4'd6, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [18:0] e_execi();
    return mk(4'd7, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 1, 0, 0);
  endfunction
  function automatic logic [18:0] e_aluwb();
    return mk(4'd8, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [18:0] e_memadr();
    return mk(4'd2, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [18:0] e_memrd();
    return mk(4'd3, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [18:0] e_memwb();
    return mk(4'd4, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 1, 0);
  endfunction
  function automatic logic [18:0] e_memwr(input logic mr);
    return mk(4'd5, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0, 1, 0, 0, mr, 0);
  endfunction
  function automatic logic [18:0] e_branch();
    return mk(4'd9, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, 0, 1, 0, 1, 0);
  endfunction

  // Scoreboard consumer: pops one expected vector per falling edge.
  task automatic sb_check();
    exp_t e;
    @(negedge clk);
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_empty: no expected entry at time %0t", $time);
    end else begin
      e = sb_q.pop_front();
      if (dut_vec !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %b, want %b", e.name, dut_vec, e.v);
      end
    end
    if (instr_done === 1'b1) begin
      done_cnt++;
      n_tests++;
      if (prev_done === 1'b1) begin
        n_fail++;
        $display("FAIL done_consecutive: got two pulses in a row, want one");
      end
    end
    prev_done = instr_done;
  endtask

  task automatic step(input logic mr, input logic [1:0] op, input logic [5:0] fn,
                      input string nm, input logic [18:0] e);
    mem_ready = mr;
    Op        = op;
    Funct     = fn;
    sb_q.push_back('{name: nm, v: e});
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic check_done(input string nm, input int d0, input int want);
    n_tests++;
    if (done_cnt - d0 !== want) begin
      n_fail++;
      $display("FAIL %s_done_count: got %0d, want %0d", nm, done_cnt - d0, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_ready = 1'b1; Op = 2'b00; Funct = 6'd0;
    #2;
    n_tests++;
    if ({state, IRWrite, NextPC, RegW, MemW, Branch, instr_done, illegal} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b, want 0",
               {state, IRWrite, NextPC, RegW, MemW, Branch, instr_done, illegal});
    end
    n_tests++;
    if ({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp} !== 8'b0_01_10_10_0) begin
      n_fail++;
      $display("FAIL reset_selects: got %b, want 00110100",
               {AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp});
    end
    @(posedge clk);
    #1;
    step(1, 2'b00, 6'd0, "rst_hold", e_rst());
    reset = 1'b1;
  endtask

  task automatic test_add();
    int d0 = done_cnt;
    step(1, 2'b00, 6'b001000, "add_fetch", e_fetch(1));
    step(1, 2'b00, 6'b001000, "add_decode", e_decode(0));
    step(1, 2'b00, 6'b001000, "add_executer", e_execr());
    step(1, 2'b00, 6'b001000, "add_aluwb", e_aluwb());
    check_done("add", d0, 1);
  endtask

  task automatic test_addi();
    int d0 = done_cnt;
    step(1, 2'b00, 6'b101000, "addi_fetch", e_fetch(1));
    step(1, 2'b00, 6'b101000, "addi_decode", e_decode(0));
    step(1, 2'b00, 6'b101000, "addi_executei", e_execi());
    step(1, 2'b00, 6'b101000, "addi_aluwb", e_aluwb());
    check_done("addi", d0, 1);
  endtask

  task automatic test_ldr_stall();
    int d0 = done_cnt;
    step(1, 2'b01, 6'b011001, "ldr_fetch", e_fetch(1));
    step(1, 2'b01, 6'b011001, "ldr_decode", e_decode(0));
    step(1, 2'b01, 6'b011001, "ldr_memadr", e_memadr());
    step(0, 2'b01, 6'b011001, "ldr_memrd_stall0", e_memrd());
    step(0, 2'b01, 6'b011001, "ldr_memrd_stall1", e_memrd());
    step(1, 2'b01, 6'b011001, "ldr_memrd_ready", e_memrd());
    step(1, 2'b01, 6'b011001, "ldr_memwb", e_memwb());
    check_done("ldr", d0, 1);
  endtask

  task automatic test_str_stall();
    int d0 = done_cnt;
    step(1, 2'b01, 6'b011000, "str_fetch", e_fetch(1));
    step(1, 2'b01, 6'b011000, "str_decode", e_decode(0));
    step(1, 2'b01, 6'b011000, "str_memadr", e_memadr());
    step(0, 2'b01, 6'b011000, "str_memwr_stall", e_memwr(0));
    step(1, 2'b01, 6'b011000, "str_memwr_ready", e_memwr(1));
    check_done("str", d0, 1);
  endtask

  task automatic test_branch();
    int d0 = done_cnt;
    step(0, 2'b10, 6'd0, "b_fetch_stall", e_fetch(0));
    step(1, 2'b10, 6'd0, "b_fetch", e_fetch(1));
    step(1, 2'b10, 6'd0, "b_decode", e_decode(0));
    step(1, 2'b10, 6'd0, "b_branch", e_branch());
    check_done("b", d0, 1);
  endtask

  task automatic test_illegal();
    int d0 = done_cnt;
    step(1, 2'b11, 6'b111111, "ill_fetch", e_fetch(1));
    step(1, 2'b11, 6'b111111, "ill_decode", e_decode(1));
    check_done("ill", d0, 1);
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt;
    step(1, 2'b11, 6'd0, "b2b_ill_fetch", e_fetch(1));
    step(1, 2'b11, 6'd0, "b2b_ill_decode", e_decode(1));
    step(1, 2'b10, 6'd0, "b2b_b_fetch", e_fetch(1));
    step(1, 2'b10, 6'd0, "b2b_b_decode", e_decode(0));
    step(1, 2'b10, 6'd0, "b2b_b_branch", e_branch());
    step(1, 2'b01, 6'b011000, "b2b_str_fetch", e_fetch(1));
    step(1, 2'b01, 6'b011000, "b2b_str_decode", e_decode(0));
    step(1, 2'b01, 6'b011000, "b2b_str_memadr", e_memadr());
    step(1, 2'b01, 6'b011000, "b2b_str_memwr", e_memwr(1));
    check_done("b2b", d0, 3);
  endtask

  task automatic test_reset_abort();
    int d0 = done_cnt;
    step(1, 2'b01, 6'b011000, "abort_fetch", e_fetch(1));
    step(1, 2'b01, 6'b011000, "abort_decode", e_decode(0));
    step(1, 2'b01, 6'b011000, "abort_memadr", e_memadr());
    mem_ready = 1'b0;
    #1;
    n_tests++;
    if ({state, MemW} !== 5'b0101_1) begin
      n_fail++;
      $display("FAIL abort_in_memwr: got %b, want 01011", {state, MemW});
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if ({state, MemW, instr_done} !== 6'd0) begin
      n_fail++;
      $display("FAIL abort_async: got %b, want 000000", {state, MemW, instr_done});
    end
    mem_ready = 1'b1;
    #1;
    n_tests++;
    if ({IRWrite, NextPC} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_strobe_gate: got %b, want 00", {IRWrite, NextPC});
    end
    sb_q.push_back('{name: "abort_rst_hold", v: e_rst()});
    sb_check();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 2'b10, 6'd0, "abort_post_fetch", e_fetch(1));
    step(1, 2'b10, 6'd0, "abort_post_decode", e_decode(0));
    step(1, 2'b10, 6'd0, "abort_post_branch", e_branch());
    check_done("abort", d0, 1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_addi();
    test_ldr_stall();
    test_str_stall();
    test_branch();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries, want 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
